// File: rtl/mcam_bus_if.sv
// CPU-side memory port as seen by the access guard: data address/qualifier,
// instruction address, and read data on its way from memory to the CPU.
interface mcam_bus_if #(
  parameter int ADDR_W = 16
);
  // No handshake: every field is sampled each cycle; mem_en alone qualifies a data access.
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [15:0]       mem_din;
  logic [15:0]       mem_dout;
  logic [15:0]       ins_addr;

  modport master (output mem_addr, mem_en, mem_din, ins_addr, input mem_dout);
  modport slave  (input mem_addr, mem_en, mem_din, ins_addr, output mem_dout);
endinterface

// File: rtl/mcam_multi_guard.sv
// Multi-region memory access guard: per-region entry tracking, violation
// detection, read-data masking, a stretched reset pulse and a sticky log.
module mcam_multi_guard #(
  parameter int                          NUM_REGIONS = 2,
  parameter int                          ADDR_W      = 16,
  parameter int                          RIDX_W      = 1,
  parameter logic [16*NUM_REGIONS-1:0]   SAFE_LO     = {NUM_REGIONS{16'd200}},
  parameter logic [16*NUM_REGIONS-1:0]   SAFE_HI     = {NUM_REGIONS{16'd200}},
  parameter logic [16*NUM_REGIONS-1:0]   CODE_LO     = {NUM_REGIONS{16'd200}},
  parameter logic [16*NUM_REGIONS-1:0]   CODE_HI     = {NUM_REGIONS{16'd200}},
  parameter int                          RST_HOLD    = 4
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  mcam_bus_if.slave              bus,
  input  logic                   disable_debug,
  input  logic                   viol_clr,
  output logic [NUM_REGIONS-1:0] in_safe_area,
  output logic                   reset,
  output logic                   viol_valid,
  output logic [RIDX_W-1:0]      viol_region,
  output logic [1:0]             viol_cause
);
  localparam int              CNT_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0]  allow_q, allow_d;
  logic [NUM_REGIONS-1:0]  in_safe, in_code, at_entry, dv, ev;
  logic                    viol_valid_q, viol_valid_d;
  logic [RIDX_W-1:0]       viol_region_q, viol_region_d, first_idx;
  logic [1:0]              viol_cause_q, viol_cause_d, first_cause;
  logic [15:0]             addr16;
  logic                    viol_any, hold;

  generate
    if (ADDR_W >= 16) begin : g_addr_trunc
      assign addr16 = bus.mem_addr[15:0];
    end else begin : g_addr_ext
      assign addr16 = {{(16-ADDR_W){1'b0}}, bus.mem_addr};
    end
  endgenerate

  always_comb begin
    in_safe  = '0;
    in_code  = '0;
    at_entry = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      in_safe[i]  = (addr16 >= SAFE_LO[16*i +: 16]) && (addr16 <= SAFE_HI[16*i +: 16]);
      in_code[i]  = (bus.ins_addr >= CODE_LO[16*i +: 16]) && (bus.ins_addr <= CODE_HI[16*i +: 16]);
      at_entry[i] = (bus.ins_addr == CODE_LO[16*i +: 16]);
    end
  end

  assign dv       = {NUM_REGIONS{bus.mem_en}} & in_safe & ~allow_q;
  assign ev       = in_code & ~at_entry & ~allow_q;
  assign viol_any = |(dv | ev);

  // Descending scan so the lowest violating region ends up recorded.
  always_comb begin
    first_idx   = '0;
    first_cause = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (dv[i] | ev[i]) begin
        first_idx   = RIDX_W'(i);
        first_cause = {ev[i], dv[i]};
      end
    end
  end

  // FSM: state register
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state; any new violation restarts the full hold length
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (viol_any && !disable_debug) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (disable_debug) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (viol_any) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    hold         = (state_q == HOLD);
    reset        = hold & ~disable_debug;
    bus.mem_dout = (!disable_debug && (reset || (|dv))) ? 16'h0000 : bus.mem_din;
  end

  always_comb begin
    allow_d = allow_q;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hold)             allow_d[i] = 1'b0;
      else if (at_entry[i]) allow_d[i] = 1'b1;
      else if (!in_code[i]) allow_d[i] = 1'b0;
    end
  end

  // A violation arriving together with viol_clr wins over the clear.
  always_comb begin
    viol_valid_d  = viol_valid_q;
    viol_region_d = viol_region_q;
    viol_cause_d  = viol_cause_q;
    if (viol_any && (!viol_valid_q || viol_clr)) begin
      viol_valid_d  = 1'b1;
      viol_region_d = first_idx;
      viol_cause_d  = first_cause;
    end else if (viol_clr) begin
      viol_valid_d  = 1'b0;
      viol_region_d = '0;
      viol_cause_d  = '0;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      allow_q       <= '0;
      viol_valid_q  <= 1'b0;
      viol_region_q <= '0;
      viol_cause_q  <= '0;
    end else begin
      allow_q       <= allow_d;
      viol_valid_q  <= viol_valid_d;
      viol_region_q <= viol_region_d;
      viol_cause_q  <= viol_cause_d;
    end
  end

  assign in_safe_area = allow_q;
  assign viol_valid   = viol_valid_q;
  assign viol_region  = viol_region_q;
  assign viol_cause   = viol_cause_q;
endmodule

// File: tb/tb_mcam_multi_guard.sv
// Bench for mcam_multi_guard: two regions, RST_HOLD=4, directed scenarios
// followed by random traffic, checked against a cycle model via a scoreboard.
module tb_mcam_multi_guard;
  localparam int NR = 2;
  localparam int RH = 4;
  localparam logic [31:0] P_SAFE_LO = {16'h9000, 16'h8000};
  localparam logic [31:0] P_SAFE_HI = {16'h90FF, 16'h80FF};
  localparam logic [31:0] P_CODE_LO = {16'h0400, 16'h0200};
  localparam logic [31:0] P_CODE_HI = {16'h04FF, 16'h02FF};

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          disable_debug;
  logic          viol_clr;
  logic [NR-1:0] in_safe_area;
  logic          reset;
  logic          viol_valid;
  logic [0:0]    viol_region;
  logic [1:0]    viol_cause;

  mcam_bus_if #(.ADDR_W(16)) bus ();

  mcam_multi_guard #(
    .NUM_REGIONS(NR), .ADDR_W(16), .RIDX_W(1),
    .SAFE_LO(P_SAFE_LO), .SAFE_HI(P_SAFE_HI),
    .CODE_LO(P_CODE_LO), .CODE_HI(P_CODE_HI),
    .RST_HOLD(RH)
  ) dut (
    .mclk(mclk), .reset_n(reset_n), .bus(bus),
    .disable_debug(disable_debug), .viol_clr(viol_clr),
    .in_safe_area(in_safe_area), .reset(reset),
    .viol_valid(viol_valid), .viol_region(viol_region), .viol_cause(viol_cause)
  );

  // clock / reset
  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_errors = 0;
  logic [22:0] exp_q[$];

  // reference model state
  logic [NR-1:0] m_allow;
  int            m_hold;   // remaining reset-high cycles, 0 = idle
  logic          m_vv;
  logic [0:0]    m_vr;
  logic [1:0]    m_vc;
  logic          obs_reset;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_allow = '0;
    m_hold  = 0;
    m_vv    = 1'b0;
    m_vr    = '0;
    m_vc    = '0;
  endtask

  // driver: one cycle of stimulus, expectation pushed, DUT sampled, model advanced
  task automatic step(input logic [15:0] ins, input logic [15:0] addr, input logic en,
                      input logic dd, input logic clr);
    logic [NR-1:0] sf, cd, ent, dv, ev;
    logic          any_v, hold;
    logic [15:0]   din;
    logic [22:0]   o;
    logic [0:0]    fi;
    logic [1:0]    fc;
    logic [31:0]   slo, shi, clo, chi;
    @(negedge mclk);
    din = 16'($urandom_range(1, 16'hFFFF));
    bus.ins_addr = ins;
    bus.mem_addr = addr;
    bus.mem_en   = en;
    bus.mem_din  = din;
    disable_debug = dd;
    viol_clr      = clr;
    slo = P_SAFE_LO; shi = P_SAFE_HI; clo = P_CODE_LO; chi = P_CODE_HI;
    for (int i = 0; i < NR; i++) begin
      sf[i]  = (addr >= slo[16*i +: 16]) && (addr <= shi[16*i +: 16]);
      cd[i]  = (ins >= clo[16*i +: 16]) && (ins <= chi[16*i +: 16]);
      ent[i] = (ins == clo[16*i +: 16]);
      dv[i]  = en && sf[i] && !m_allow[i];
      ev[i]  = cd[i] && !ent[i] && !m_allow[i];
    end
    any_v = |(dv | ev);
    hold  = (m_hold > 0);
    exp_q.push_back({m_allow, hold && !dd, m_vv, m_vr, m_vc,
                     (!dd && (hold || (|dv))) ? 16'h0000 : din});
    #1;
    o = {in_safe_area, reset, viol_valid, viol_region, viol_cause, bus.mem_dout};
    check("cycle_outputs", {9'd0, o}, {9'd0, exp_q.pop_front()});
    obs_reset = reset;
    @(posedge mclk);
    fi = '0; fc = '0;
    for (int i = NR - 1; i >= 0; i--)
      if (dv[i] || ev[i]) begin fi = 1'(i); fc = {ev[i], dv[i]}; end
    if (any_v && (!m_vv || clr)) begin
      m_vv = 1'b1; m_vr = fi; m_vc = fc;
    end else if (clr) begin
      m_vv = 1'b0; m_vr = '0; m_vc = '0;
    end
    for (int i = 0; i < NR; i++) begin
      if (hold)        m_allow[i] = 1'b0;
      else if (ent[i]) m_allow[i] = 1'b1;
      else if (!cd[i]) m_allow[i] = 1'b0;
    end
    if (any_v && !dd) m_hold = RH;
    else if (hold && dd) m_hold = 0;
    else if (hold) m_hold = m_hold - 1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic count_pulse(input string tag, input int n, input int exp_len);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
      if (obs_reset) cnt++;
    end
    check(tag, cnt, exp_len);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_allow"},  {30'd0, in_safe_area}, 32'd0);
    check({tag, "_reset"},  {31'd0, reset},        32'd0);
    check({tag, "_vvalid"}, {31'd0, viol_valid},   32'd0);
    check({tag, "_vregion"},{31'd0, viol_region},  32'd0);
    check({tag, "_vcause"}, {30'd0, viol_cause},   32'd0);
  endtask

  logic [15:0] ins_set[8]  = '{16'h0100, 16'h0200, 16'h0204, 16'h0250,
                               16'h0300, 16'h0400, 16'h0420, 16'h04FF};
  logic [15:0] addr_set[6] = '{16'h8000, 16'h8010, 16'h80FF, 16'h8100,
                               16'h9010, 16'h0000};

  initial begin
    reset_n = 1'b0;
    bus.ins_addr = 16'h0100; bus.mem_addr = '0; bus.mem_en = 1'b0; bus.mem_din = '0;
    disable_debug = 1'b0; viol_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge mclk);
    check_reset_state("por");
    #2 reset_n = 1'b1;

    // legal entry then safe access
    step(16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h0204, 16'h8010, 1'b1, 1'b0, 1'b0);
    step(16'h0208, 16'h80FF, 1'b1, 1'b0, 1'b0);
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);

    // illegal data access from outside the code range
    step(16'h0100, 16'h8010, 1'b1, 1'b0, 1'b0);
    count_pulse("pulse_data", 6, RH);
    check("cause_data", {30'd0, viol_cause}, 32'd1);

    // mid-code entry, then legal entry and exit
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(16'h0250, 16'h0000, 1'b0, 1'b0, 1'b0);
    count_pulse("pulse_entry", 6, RH);
    check("cause_entry", {30'd0, viol_cause}, 32'd2);
    step(16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h0210, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h0300, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);

    // region1 violation while log is held, then clear racing a new violation
    step(16'h0100, 16'h9010, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(16'h0100, 16'h9010, 1'b1, 1'b0, 1'b1);
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("clr_race_region", {31'd0, viol_region}, 32'd1);
    idle(5);

    // disable_debug: no reset, no masking, still logged
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1);
    step(16'h0100, 16'h8010, 1'b1, 1'b1, 1'b0);
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("dd_logged", {31'd0, viol_valid}, 32'd1);

    // back-to-back violations stretch the pulse
    for (int k = 0; k < 3; k++) step(16'h0100, 16'h8010, 1'b1, 1'b0, 1'b0);
    count_pulse("pulse_stretch", 6, RH);

    // disable_debug during hold drops reset at once
    step(16'h0100, 16'h8010, 1'b1, 1'b0, 1'b0);
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h0100, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle(3);

    // async reset in the middle of a hold
    step(16'h0100, 16'h8010, 1'b1, 1'b0, 1'b0);
    step(16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("pre_async_hold", {31'd0, obs_reset}, 32'd1);
    @(negedge mclk);
    reset_n = 1'b0;
    #1;
    check_reset_state("async");
    model_reset();
    #2 reset_n = 1'b1;
    step(16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(16'h0204, 16'h8010, 1'b1, 1'b0, 1'b0);
    idle(2);

    // random traffic
    for (int k = 0; k < 300; k++)
      step(ins_set[$urandom_range(0, 7)], addr_set[$urandom_range(0, 5)],
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) == 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
